// File: rtl/video_mode_cmd_tx.sv
`default_nettype none

// Command codes placed on the bus for each video mode. IDLE_CODE must differ
// from all three of these codes.
`ifndef MODE_VGA
`define MODE_VGA   8'h01
`endif
`ifndef MODE_720p
`define MODE_720p  8'h02
`endif
`ifndef MODE_1080p
`define MODE_1080p 8'h03
`endif

// ============================================================================
// Module   : video_mode_cmd_tx
// Brief    : Transmit side of the 8-bit video-mode command bus. Converts
//            valid/ready mode requests into level-coded commands, each held
//            HOLD_CYCLES and followed by GAP_CYCLES of IDLE_CODE so that the
//            receiver always sees a bus change. One-entry pending slot.
// Revision : 1.0 - initial release
// ============================================================================
module video_mode_cmd_tx #(
    parameter int          HOLD_CYCLES = 16,
    parameter int          GAP_CYCLES  = 16,
    parameter logic [7:0]  IDLE_CODE   = 8'h00,
    parameter int          RESEND_SAME = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_mode,
    output logic [7:0] data_out,
    output logic       busy,
    output logic [1:0] current_mode,
    output logic       err_invalid
);

    localparam int c_MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_CNT_W      = (c_MAX_CYCLES < 2) ? 1 : $clog2(c_MAX_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD  = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [1:0] c_MODE_INVALID = 2'd3;
    localparam logic [1:0] c_MODE_RESET   = 2'd2;   // receiver power-up default: 1080p

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Bus code for a valid mode
    function automatic logic [7:0] f_code(input logic [1:0] mode);
        case (mode)
            2'd0:    f_code = `MODE_VGA;
            2'd1:    f_code = `MODE_720p;
            default: f_code = `MODE_1080p;
        endcase
    endfunction

    state_t             r_state, w_state;
    logic [c_CNT_W-1:0] r_cnt, w_cnt;
    logic               r_pend_valid, w_pend_valid;
    logic [1:0]         r_pend_mode, w_pend_mode;
    logic               r_ready, w_ready;
    logic [7:0]         r_data, w_data;
    logic               r_busy, w_busy;
    logic [1:0]         r_cur, w_cur;
    logic               r_err, w_err;

    logic               w_accept;
    logic               w_acc_mode;     // accepted request carrying a real mode
    logic               w_cand_valid;
    logic [1:0]         w_cand_mode;
    logic               w_launch;
    logic [1:0]         w_launch_mode;

    assign w_accept   = req_valid && r_ready;
    assign w_acc_mode = w_accept && (req_mode != c_MODE_INVALID);

    // Next-state, launch decision and registered-output values
    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_pend_valid  = r_pend_valid;
        w_pend_mode   = r_pend_mode;
        w_data        = r_data;
        w_busy        = r_busy;
        w_cur         = r_cur;
        w_err         = w_accept && (req_mode == c_MODE_INVALID);
        w_cand_valid  = 1'b0;
        w_cand_mode   = 2'd0;
        w_launch      = 1'b0;
        w_launch_mode = 2'd0;

        case (r_state)
            ST_IDLE: begin
                if (w_acc_mode && ((req_mode != r_cur) || (RESEND_SAME != 0))) begin
                    w_launch      = 1'b1;
                    w_launch_mode = req_mode;
                end
            end
            ST_SEND: begin
                if (r_cnt == '0) begin
                    w_state = ST_GAP;
                    w_cnt   = c_GAP_LOAD;
                    w_data  = IDLE_CODE;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
                if (w_acc_mode) begin
                    w_pend_valid = 1'b1;
                    w_pend_mode  = req_mode;
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    // Last gap cycle: the pending slot has priority over a fresh request
                    if (r_pend_valid) begin
                        w_cand_valid = 1'b1;
                        w_cand_mode  = r_pend_mode;
                    end else if (w_acc_mode) begin
                        w_cand_valid = 1'b1;
                        w_cand_mode  = req_mode;
                    end
                    w_pend_valid = 1'b0;
                    if (w_cand_valid && ((w_cand_mode != r_cur) || (RESEND_SAME != 0))) begin
                        w_launch      = 1'b1;
                        w_launch_mode = w_cand_mode;
                    end else begin
                        w_state = ST_IDLE;
                        w_busy  = 1'b0;
                        w_data  = IDLE_CODE;
                    end
                end else begin
                    w_cnt = r_cnt - 1'b1;
                    if (w_acc_mode) begin
                        w_pend_valid = 1'b1;
                        w_pend_mode  = req_mode;
                    end
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_busy  = 1'b0;
                w_data  = IDLE_CODE;
            end
        endcase

        if (w_launch) begin
            w_state = ST_SEND;
            w_cnt   = c_HOLD_LOAD;
            w_data  = f_code(w_launch_mode);
            w_cur   = w_launch_mode;
            w_busy  = 1'b1;
        end

        w_ready = !w_pend_valid;
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_pend_valid <= 1'b0;
            r_pend_mode  <= 2'd0;
            r_ready      <= 1'b1;
            r_data       <= IDLE_CODE;
            r_busy       <= 1'b0;
            r_cur        <= c_MODE_RESET;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_pend_valid <= w_pend_valid;
            r_pend_mode  <= w_pend_mode;
            r_ready      <= w_ready;
            r_data       <= w_data;
            r_busy       <= w_busy;
            r_cur        <= w_cur;
            r_err        <= w_err;
        end
    end

    assign req_ready    = r_ready;
    assign data_out     = r_data;
    assign busy         = r_busy;
    assign current_mode = r_cur;
    assign err_invalid  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_video_mode_cmd_tx.sv
`default_nettype none

// ============================================================================
// Module   : tb_video_mode_cmd_tx
// Brief    : Self-checking bench for video_mode_cmd_tx. Two instances (default
//            parameters, and 1/1-cycle timing with resend enabled) share one
//            stimulus stream; each is compared every cycle to a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_mode_cmd_tx;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_mode = 2'd0;

    logic       d0_ready, d0_busy, d0_err;
    logic [7:0] d0_data;
    logic [1:0] d0_cur;
    logic       d1_ready, d1_busy, d1_err;
    logic [7:0] d1_data;
    logic [1:0] d1_cur;

    int n_cmp = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    video_mode_cmd_tx u_dut0 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(d0_ready),
        .req_mode(req_mode), .data_out(d0_data), .busy(d0_busy),
        .current_mode(d0_cur), .err_invalid(d0_err)
    );

    video_mode_cmd_tx #(
        .HOLD_CYCLES(1), .GAP_CYCLES(1), .IDLE_CODE(8'h00), .RESEND_SAME(1)
    ) u_dut1 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(d1_ready),
        .req_mode(req_mode), .data_out(d1_data), .busy(d1_busy),
        .current_mode(d1_cur), .err_invalid(d1_err)
    );

    // Expected bus codes
    function automatic logic [7:0] code_of(input logic [1:0] m);
        case (m)
            2'd0:    code_of = 8'h01;
            2'd1:    code_of = 8'h02;
            default: code_of = 8'h03;
        endcase
    endfunction

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a command "lives" for H+G cycles counted by its age;
    // it is on the bus for the first H of them. A one-deep slot holds a waiting mode.
    int         m_hold [2] = '{16, 1};
    int         m_gap  [2] = '{16, 1};
    bit         m_rs   [2] = '{1'b0, 1'b1};
    bit         m_active [2] = '{1'b0, 1'b0};
    int         m_age    [2] = '{0, 0};
    logic [1:0] m_cur    [2] = '{2'd2, 2'd2};
    bit         m_pv     [2] = '{1'b0, 1'b0};
    logic [1:0] m_pm     [2] = '{2'd0, 2'd0};
    bit         m_err    [2] = '{1'b0, 1'b0};

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            bit         acc, nv, cv;
            logic [1:0] cm;
            acc = req_valid && !m_pv[i];
            nv  = acc && (req_mode != 2'd3);
            cv  = 1'b0;
            cm  = 2'd0;
            if (reset) begin
                m_active[i] <= 1'b0;
                m_age[i]    <= 0;
                m_cur[i]    <= 2'd2;
                m_pv[i]     <= 1'b0;
                m_err[i]    <= 1'b0;
            end else begin
                m_err[i] <= acc && (req_mode == 2'd3);
                if (!m_active[i]) begin
                    if (nv && ((req_mode != m_cur[i]) || m_rs[i])) begin
                        m_active[i] <= 1'b1;
                        m_age[i]    <= 0;
                        m_cur[i]    <= req_mode;
                    end
                end else if (m_age[i] == m_hold[i] + m_gap[i] - 1) begin
                    if (m_pv[i]) begin
                        cv = 1'b1;
                        cm = m_pm[i];
                    end else if (nv) begin
                        cv = 1'b1;
                        cm = req_mode;
                    end
                    m_pv[i] <= 1'b0;
                    if (cv && ((cm != m_cur[i]) || m_rs[i])) begin
                        m_age[i] <= 0;
                        m_cur[i] <= cm;
                    end else begin
                        m_active[i] <= 1'b0;
                    end
                end else begin
                    m_age[i] <= m_age[i] + 1;
                    if (nv) begin
                        m_pv[i] <= 1'b1;
                        m_pm[i] <= req_mode;
                    end
                end
            end
        end
    end

    task automatic compare_dut(input int i, input logic [7:0] data, input logic bsy,
                               input logic rdy, input logic [1:0] cur, input logic err);
        logic [7:0] exp_data;
        exp_data = (m_active[i] && (m_age[i] < m_hold[i])) ? code_of(m_cur[i]) : 8'h00;
        check_value($sformatf("d%0d_data", i),  32'(data), 32'(exp_data));
        check_value($sformatf("d%0d_busy", i),  32'(bsy),  32'(m_active[i]));
        check_value($sformatf("d%0d_ready", i), 32'(rdy),  32'(!m_pv[i]));
        check_value($sformatf("d%0d_cur", i),   32'(cur),  32'(m_cur[i]));
        check_value($sformatf("d%0d_err", i),   32'(err),  32'(m_err[i]));
    endtask

    // Every cycle, away from the active edge, compare both instances to the model
    always @(negedge clock) begin
        if (chk_en) begin
            compare_dut(0, d0_data, d0_busy, d0_ready, d0_cur, d0_err);
            compare_dut(1, d1_data, d1_busy, d1_ready, d1_cur, d1_err);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        int k;
        step(1);
        chk_en = 1'b1;
        do_reset();

        // Reset values
        step(1);
        check_value("rst_data",  32'(d0_data), 32'h00);
        check_value("rst_busy",  32'(d0_busy), 32'd0);
        check_value("rst_ready", 32'(d0_ready), 32'd1);
        check_value("rst_cur",   32'(d0_cur),  32'd2);
        check_value("rst_err",   32'(d0_err),  32'd0);

        // Single VGA command: 16 cycles on the bus, 16 cycles of gap
        req_valid = 1'b1; req_mode = 2'd0;
        step(1);
        req_valid = 1'b0;
        check_value("vga_first",  32'(d0_data), 32'h01);
        check_value("vga_cur",    32'(d0_cur),  32'd0);
        step(15);
        check_value("vga_last",   32'(d0_data), 32'h01);
        step(1);
        check_value("gap_first",  32'(d0_data), 32'h00);
        check_value("gap_busy",   32'(d0_busy), 32'd1);
        step(15);
        check_value("gap_last_busy", 32'(d0_busy), 32'd1);
        step(1);
        check_value("idle_busy",  32'(d0_busy), 32'd0);

        // Same-as-current request: dropped by default, resent by the resend instance
        do_reset();
        req_valid = 1'b1; req_mode = 2'd2;
        step(1);
        req_valid = 1'b0;
        check_value("drop_busy",  32'(d0_busy), 32'd0);
        check_value("drop_data",  32'(d0_data), 32'h00);
        check_value("resend_data", 32'(d1_data), 32'h03);

        // 720p, then 1080p into the slot, then VGA held valid and stalled
        do_reset();
        step(2);
        req_valid = 1'b1; req_mode = 2'd1;
        step(1);
        req_valid = 1'b0;
        step(4);
        req_valid = 1'b1; req_mode = 2'd2;
        step(1);
        req_mode = 2'd0;
        check_value("slot_full_ready", 32'(d0_ready), 32'd0);
        k = 0;
        while (!d0_ready && k < 100) begin
            step(1);
            k++;
        end
        check_value("stall_cycles", 32'(k), 32'd27);
        check_value("pend_launch",  32'(d0_data), 32'h03);
        step(1);
        req_valid = 1'b0;
        check_value("vga_pending_ready", 32'(d0_ready), 32'd0);
        step(30);
        check_value("gap_before_vga", 32'(d0_data), 32'h00);
        step(1);
        check_value("vga_launch", 32'(d0_data), 32'h01);

        // Invalid mode while idle
        do_reset();
        step(1);
        req_valid = 1'b1; req_mode = 2'd3;
        step(1);
        req_valid = 1'b0;
        check_value("inv_err",  32'(d0_err),  32'd1);
        check_value("inv_busy", 32'(d0_busy), 32'd0);
        step(1);
        check_value("inv_err_gone", 32'(d0_err), 32'd0);

        // Reset during SEND with the slot full
        do_reset();
        req_valid = 1'b1; req_mode = 2'd1;
        step(1);
        req_mode = 2'd0;
        step(1);
        req_valid = 1'b0;
        step(5);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_value("mid_rst_data",  32'(d0_data),  32'h00);
        check_value("mid_rst_busy",  32'(d0_busy),  32'd0);
        check_value("mid_rst_ready", 32'(d0_ready), 32'd1);
        check_value("mid_rst_cur",   32'(d0_cur),   32'd2);
        step(40);
        check_value("pend_lost", 32'(d0_busy), 32'd0);

        // Random traffic, occasional reset
        for (int c = 0; c < 4000; c++) begin
            reset     = ($urandom_range(0, 299) == 0);
            req_valid = ($urandom_range(0, 2) == 0);
            req_mode  = 2'($urandom_range(0, 3));
            step(1);
        end
        reset = 1'b0;
        req_valid = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
